// File: rtl/axil_arb_pkg.sv
// Shared definitions for the AXI4-Lite master arbiter: FSM encoding and sizing helper.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package axil_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arb_state_t;

   // Ceiling log2, usable in constant expressions for port and counter widths.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/axil_master_arbiter_rr_arbiter.sv
// Round-robin grant: first valid request at or after the pointer, wrapping.
// Latency: grant is combinational; pointer moves on the accept edge.
// Backpressure: losers get no grant and must keep their request asserted.
module rr_arbiter
   import axil_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                       m_axi_aclk,
   input  logic                       m_axi_aresetn,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       accept,
   output logic [NUM_REQ-1:0]         grant_oh,
   output logic [clog2(NUM_REQ)-1:0]  grant_idx,
   output logic                       any_req
);

   localparam int IW = clog2(NUM_REQ);

   logic [IW-1:0] ptr;
   logic [IW-1:0] cand_idx;
   int            cand;

   // Scan from the pointer, wrapping, and pick the first pending request.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = IW'(cand);
         if (!any_req && req[cand_idx]) begin
            any_req            = 1'b1;
            grant_idx          = cand_idx;
            grant_oh[cand_idx] = 1'b1;
         end
      end
   end

   // Pointer moves one past the winner so it has lowest priority next time.
   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         ptr <= '0;
      end else if (accept) begin
         if (grant_idx == IW'(NUM_REQ - 1)) ptr <= '0;
         else                               ptr <= grant_idx + IW'(1);
      end
   end

endmodule

// File: rtl/axil_master_arbiter.sv
// Shares one AXI4-Lite master core among NUM_REQ requesters, one transaction at a time.
// Latency: accept -> enable 1 cycle; done sampled -> rsp_valid 1 cycle; abort after TIMEOUT_CYCLES.
// Backpressure: req_ready only in IDLE to the round-robin winner; others hold req_valid.
module axil_master_arbiter
   import axil_arb_pkg::*;
#(
   parameter int NUM_REQ            = 4,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES     = 1024
) (
   input  logic                                  m_axi_aclk,
   input  logic                                  m_axi_aresetn,
   input  logic [NUM_REQ-1:0]                    req_valid,
   output logic [NUM_REQ-1:0]                    req_ready,
   input  logic [NUM_REQ-1:0]                    req_write,
   input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]                    rsp_valid,
   output logic [C_M_AXI_DATA_WIDTH-1:0]         rsp_rdata,
   output logic                                  rsp_err,
   output logic                                  mst_read_ena,
   output logic                                  mst_write_ena,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]         mst_read_addr,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]         mst_write_addr,
   output logic [C_M_AXI_DATA_WIDTH-1:0]         mst_write_data,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]         mst_read_data,
   input  logic                                  mst_read_done,
   input  logic                                  mst_write_done,
   output logic                                  busy,
   output logic [clog2(NUM_REQ)-1:0]             grant_id
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int IW = clog2(NUM_REQ);
   localparam int CW = (clog2(TIMEOUT_CYCLES) > 0) ? clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   arb_state_t        state, state_nxt;
   req_t              cap;
   logic [NUM_REQ-1:0] grant_oh;
   logic [IW-1:0]     grant_idx;
   logic              any_req;
   logic              accept;
   logic              done_hit;
   logic              to_hit;
   logic [CW-1:0]     to_cnt;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .m_axi_aclk    (m_axi_aclk),
      .m_axi_aresetn (m_axi_aresetn),
      .req           (req_valid),
      .accept        (accept),
      .grant_oh      (grant_oh),
      .grant_idx     (grant_idx),
      .any_req       (any_req)
   );

   // Accept only from IDLE; the core sees only the captured request, never live inputs.
   always_comb begin
      req_ready = '0;
      if (state == ST_IDLE && m_axi_aresetn && any_req) req_ready = grant_oh;
      accept   = |req_ready;
      done_hit = (state == ST_ISSUE) && (cap.write ? mst_write_done : mst_read_done);
      to_hit   = (TIMEOUT_CYCLES != 0) && (state == ST_ISSUE) && (to_cnt == TO_LAST);
   end

   // Next-state logic; done is checked ahead of the watchdog so it wins a tie.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
         ST_ISSUE: if (done_hit || to_hit) state_nxt = ST_RESP;
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) state <= ST_IDLE;
      else                state <= state_nxt;
   end

   // Capture the winner's request so addr/data stay stable for the whole ISSUE phase.
   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         cap      <= '0;
         grant_id <= '0;
      end else if (accept) begin
         cap.write <= req_write[grant_idx];
         cap.addr  <= req_addr[grant_idx*AW +: AW];
         cap.wdata <= req_wdata[grant_idx*DW +: DW];
         grant_id  <= grant_idx;
      end
   end

   // Watchdog counts ISSUE cycles, restarted by every accept.
   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn || accept) to_cnt <= '0;
      else if (state == ST_ISSUE)  to_cnt <= to_cnt + CW'(1);
   end

   // Response registers hold until the next completion or abort.
   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (done_hit) begin
         rsp_rdata <= cap.write ? '0 : mst_read_data;
         rsp_err   <= 1'b0;
      end else if (to_hit) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b1;
      end
   end

   // Enables decode from registered state, so they drop the edge after done or reset.
   always_comb begin
      mst_read_ena   = (state == ST_ISSUE) && !cap.write;
      mst_write_ena  = (state == ST_ISSUE) &&  cap.write;
      mst_read_addr  = cap.addr;
      mst_write_addr = cap.addr;
      mst_write_data = cap.wdata;
      busy           = (state != ST_IDLE);
      rsp_valid      = '0;
      if (state == ST_RESP) rsp_valid[grant_id] = 1'b1;
   end

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter with the master core modelled by the stimulus.
// Latency: checks the 1-cycle accept->enable and done->rsp_valid timing.
// Backpressure: checks that non-winning requesters see no req_ready.
module tb_axil_master_arbiter;

   logic         clk = 1'b0;
   logic         aresetn = 1'b0;
   logic [3:0]   req_valid = '0;
   logic [3:0]   req_ready;
   logic [3:0]   req_write = '0;
   logic [127:0] req_addr = '0;
   logic [127:0] req_wdata = '0;
   logic [3:0]   rsp_valid;
   logic [31:0]  rsp_rdata;
   logic         rsp_err;
   logic         mst_read_ena, mst_write_ena;
   logic [31:0]  mst_read_addr, mst_write_addr, mst_write_data;
   logic [31:0]  mst_read_data = '0;
   logic         mst_read_done = 1'b0;
   logic         mst_write_done = 1'b0;
   logic         busy;
   logic [1:0]   grant_id;

   int   checks = 0;
   int   errors = 0;
   int   rd_rises = 0;
   int   wr_rises = 0;
   int   low_run = 0;
   logic prev_rd = 1'b0, prev_wr = 1'b0, prev_en = 1'b0;
   logic seen_txn = 1'b0, gap_viol = 1'b0, en_now;

   axil_master_arbiter #(
      .NUM_REQ            (4),
      .C_M_AXI_ADDR_WIDTH (32),
      .C_M_AXI_DATA_WIDTH (32),
      .TIMEOUT_CYCLES     (16)
   ) dut (
      .m_axi_aclk     (clk),
      .m_axi_aresetn  (aresetn),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .mst_read_ena   (mst_read_ena),
      .mst_write_ena  (mst_write_ena),
      .mst_read_addr  (mst_read_addr),
      .mst_write_addr (mst_write_addr),
      .mst_write_data (mst_write_data),
      .mst_read_data  (mst_read_data),
      .mst_read_done  (mst_read_done),
      .mst_write_done (mst_write_done),
      .busy           (busy),
      .grant_id       (grant_id)
   );

   always #5 clk = ~clk;

   // Count enable rising edges and the shortest enables-low gap between transactions.
   always @(negedge clk) begin
      if (!aresetn) begin
         prev_rd  = 1'b0;
         prev_wr  = 1'b0;
         prev_en  = 1'b0;
         seen_txn = 1'b0;
         low_run  = 0;
      end else begin
         if (mst_read_ena && !prev_rd)  rd_rises++;
         if (mst_write_ena && !prev_wr) wr_rises++;
         en_now = mst_read_ena | mst_write_ena;
         if (en_now && !prev_en) begin
            if (seen_txn && low_run < 2) gap_viol = 1'b1;
            seen_txn = 1'b1;
         end
         low_run = en_now ? 0 : low_run + 1;
         prev_rd = mst_read_ena;
         prev_wr = mst_write_ena;
         prev_en = en_now;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state, including no req_ready while reset is held.
      req_valid = 4'b1111;
      step();
      step();
      #1;
      chk("rst_ready", req_ready, 4'b0000);
      req_valid = 4'b0000;
      chk("rst_busy", busy, 1'b0);
      chk("rst_rd_ena", mst_read_ena, 1'b0);
      chk("rst_wr_ena", mst_write_ena, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 4'b0000);
      chk("rst_grant_id", grant_id, 2'd0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      aresetn = 1'b1;
      step();

      // Single read from requester 1.
      req_write = 4'b0000;
      req_addr[32 +: 32] = 32'h10;
      req_valid = 4'b0010;
      #1;
      chk("rd_ready", req_ready, 4'b0010);
      step();
      req_valid = 4'b0000;
      chk("rd_ena", mst_read_ena, 1'b1);
      chk("rd_wr_ena", mst_write_ena, 1'b0);
      chk("rd_addr", mst_read_addr, 32'h10);
      chk("rd_grant_id", grant_id, 2'd1);
      chk("rd_busy", busy, 1'b1);
      step();
      mst_read_done = 1'b1;
      mst_read_data = 32'hDEADBEEF;
      step();
      mst_read_done = 1'b0;
      mst_read_data = 32'h0;
      chk("rd_ena_drop", mst_read_ena, 1'b0);
      chk("rd_rsp_valid", rsp_valid, 4'b0010);
      chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("rd_rsp_err", rsp_err, 1'b0);
      step();
      chk("rd_rsp_pulse", rsp_valid, 4'b0000);
      chk("rd_idle", busy, 1'b0);
      chk("rd_rises", rd_rises, 1);
      chk("rd_wr_rises", wr_rises, 0);

      // A done strobe while idle must be ignored.
      mst_read_done = 1'b1;
      mst_read_data = 32'h55;
      step();
      mst_read_done = 1'b0;
      chk("idle_done_busy", busy, 1'b0);
      chk("idle_done_rsp", rsp_valid, 4'b0000);
      chk("idle_done_hold", rsp_rdata, 32'hDEADBEEF);

      // Single write from requester 2, with a stray read_done during ISSUE.
      req_write[2] = 1'b1;
      req_addr[64 +: 32] = 32'h20;
      req_wdata[64 +: 32] = 32'hA5A5A5A5;
      req_valid = 4'b0100;
      #1;
      chk("wr_ready", req_ready, 4'b0100);
      step();
      req_valid = 4'b0000;
      chk("wr_ena", mst_write_ena, 1'b1);
      chk("wr_rd_ena", mst_read_ena, 1'b0);
      chk("wr_addr", mst_write_addr, 32'h20);
      chk("wr_data", mst_write_data, 32'hA5A5A5A5);
      chk("wr_grant_id", grant_id, 2'd2);
      mst_read_done = 1'b1;
      mst_read_data = 32'h77;
      step();
      mst_read_done = 1'b0;
      chk("wr_stray_busy", busy, 1'b1);
      chk("wr_stray_rsp", rsp_valid, 4'b0000);
      mst_write_done = 1'b1;
      step();
      mst_write_done = 1'b0;
      chk("wr_rsp_valid", rsp_valid, 4'b0100);
      chk("wr_rsp_rdata", rsp_rdata, 32'h0);
      chk("wr_rsp_err", rsp_err, 1'b0);
      chk("wr_ena_drop", mst_write_ena, 1'b0);
      step();
      chk("wr_rises", wr_rises, 1);

      // Reset in the middle of a write from requester 1 (pointer is 3 before this).
      req_write = 4'b0010;
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0000;
      chk("rstmid_wr_ena", mst_write_ena, 1'b1);
      aresetn = 1'b0;
      step();
      chk("rstmid_wr_ena0", mst_write_ena, 1'b0);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_rsp", rsp_valid, 4'b0000);
      chk("rstmid_gid", grant_id, 2'd0);
      step();
      chk("rstmid_rsp2", rsp_valid, 4'b0000);
      aresetn = 1'b1;
      req_write = 4'b0000;
      req_valid = 4'b1010;
      #1;
      chk("rstmid_lowest", req_ready, 4'b0010);

      // All four held valid: strict round-robin from index 0.
      req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk("rr_ready", req_ready, 64'(1) << (k % 4));
         step();
         chk("rr_grant", grant_id, 64'(k % 4));
         chk("rr_rd_ena", mst_read_ena, 1'b1);
         mst_read_done = 1'b1;
         mst_read_data = 32'h100 + 32'(k);
         step();
         mst_read_done = 1'b0;
         chk("rr_rsp_valid", rsp_valid, 64'(1) << (k % 4));
         chk("rr_rsp_rdata", rsp_rdata, 64'(32'h100 + 32'(k)));
         if (k == 7) req_valid = 4'b0000;
         step();
      end
      chk("rr_gap", gap_viol, 1'b0);
      chk("rr_rd_rises", rd_rises, 9);

      // Watchdog: read from requester 1 never completes; requester 2 waits.
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0100;
      repeat (15) step();
      chk("to_busy", busy, 1'b1);
      chk("to_rd_ena", mst_read_ena, 1'b1);
      chk("to_no_rsp", rsp_valid, 4'b0000);
      chk("to_wait_ready", req_ready, 4'b0000);
      step();
      chk("to_rsp_valid", rsp_valid, 4'b0010);
      chk("to_rsp_err", rsp_err, 1'b1);
      chk("to_rsp_rdata", rsp_rdata, 32'h0);
      chk("to_rd_ena0", mst_read_ena, 1'b0);
      step();
      chk("to_next_ready", req_ready, 4'b0100);
      step();
      req_valid = 4'b0000;
      chk("to_next_grant", grant_id, 2'd2);
      chk("to_next_ena", mst_read_ena, 1'b1);

      // Done arriving on the last allowed ISSUE cycle beats the watchdog.
      repeat (15) step();
      mst_read_done = 1'b1;
      mst_read_data = 32'h12345678;
      step();
      mst_read_done = 1'b0;
      chk("tie_rsp_valid", rsp_valid, 4'b0100);
      chk("tie_rsp_err", rsp_err, 1'b0);
      chk("tie_rsp_rdata", rsp_rdata, 32'h12345678);
      step();
      chk("tie_idle", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
